// File: rtl/modmul_sched_pkg.sv
// Shared constants and types for the modular-multiply scheduler: the modulus
// (secp256k1 group order n), FSM encoding and a single-subtract reduction.
package modmul_sched_pkg;

  localparam logic [255:0] N_ORDER =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

  localparam int DEFAULT_TIMEOUT = 4096;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Valid only for x < 2*N_ORDER, which every caller guarantees.
  function automatic logic [255:0] mod_reduce(input logic [256:0] x);
    logic [256:0] diff;
    diff = x - {1'b0, N_ORDER};
    return (x >= {1'b0, N_ORDER}) ? diff[255:0] : x[255:0];
  endfunction

endpackage

// File: rtl/modmul_sched_barrett.sv
// 256-bit modular multiplier c = a*b mod n, one bit of b per cycle (MSB first).
// Operands must stay stable from reset release until done_o; done_o then holds.
module modmul_sched_barrett
  import modmul_sched_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] a_i,
  input  logic [255:0] b_i,
  output logic         done_o,
  output logic [255:0] c_o
);

  logic [255:0] acc_q, acc_d;
  logic [8:0]   step_q, step_d;
  logic [255:0] a_red;
  logic [255:0] dbl_red;
  logic [256:0] sum;
  logic [7:0]   bit_idx;
  logic         b_bit;

  always_comb begin
    // a may be >= n; any 256-bit value is below 2n, so one subtract suffices.
    a_red   = mod_reduce({1'b0, a_i});
    bit_idx = ~step_q[7:0];
    b_bit   = b_i[bit_idx];
    dbl_red = mod_reduce({acc_q, 1'b0});
    sum     = {1'b0, dbl_red} + (b_bit ? {1'b0, a_red} : 257'd0);
    acc_d   = acc_q;
    step_d  = step_q;
    if (!step_q[8]) begin
      acc_d  = mod_reduce(sum);
      step_d = step_q + 9'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      step_q <= '0;
    end else begin
      acc_q  <= acc_d;
      step_q <= step_d;
    end
  end

  assign done_o = step_q[8];
  assign c_o    = acc_q;

endmodule

// File: rtl/modmul_sched.sv
// Round-robin scheduler sharing one 256-bit modular multiplier among N_REQ
// requesters: grant, restart the multiplier, wait (with timeout), respond.
module modmul_sched
  import modmul_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [256*N_REQ-1:0]   op_a,
  input  logic [256*N_REQ-1:0]   op_b,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [255:0]           rsp_c,
  output logic                   rsp_err,
  output logic                   busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [255:0]       a_q, a_d;
  logic [255:0]       b_q, b_d;
  logic [255:0]       rsp_c_q, rsp_c_d;
  logic               rsp_err_q, rsp_err_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0]   tmo_q, tmo_d, tmo_inc;
  logic               start_rst_n_q, start_rst_n_d;

  logic               mul_rst_n;
  logic               mul_done;
  logic [255:0]       mul_c;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   owner_next;

  logic [255:0]       slice_a [N_REQ];
  logic [255:0]       slice_b [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign slice_a[gi] = op_a[256*gi +: 256];
      assign slice_b[gi] = op_b[256*gi +: 256];
    end
  endgenerate

  // First requester at or after rr_ptr, wrapping; descending loop so the
  // smallest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    int s;
    logic [IDX_W-1:0] cand;
    s          = 0;
    cand       = '0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      s = int'(rr_ptr_q) + k;
      if (s >= N_REQ) s = s - N_REQ;
      cand = IDX_W'(s);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign owner_next = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
  assign tmo_inc    = tmo_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    a_d           = a_q;
    b_d           = b_q;
    rsp_c_d       = rsp_c_q;
    rsp_err_d     = rsp_err_q;
    gnt_d         = '0;
    rsp_valid_d   = '0;
    tmo_d         = tmo_q;
    start_rst_n_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d[pick_idx] = 1'b1;
          owner_d         = pick_idx;
          a_d             = slice_a[pick_idx];
          b_d             = slice_b[pick_idx];
          tmo_d           = '0;
          start_rst_n_d   = 1'b0;
          state_d         = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (mul_done) begin
          rsp_c_d   = mul_c;
          rsp_err_d = 1'b0;
          state_d   = ST_RESP;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == CNT_W'(TIMEOUT)) begin
            rsp_c_d   = '0;
            rsp_err_d = 1'b1;
            state_d   = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        rsp_valid_d[owner_q] = 1'b1;
        rr_ptr_d             = owner_next;
        state_d              = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      a_q           <= '0;
      b_q           <= '0;
      rsp_c_q       <= '0;
      rsp_err_q     <= 1'b0;
      gnt_q         <= '0;
      rsp_valid_q   <= '0;
      tmo_q         <= '0;
      start_rst_n_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      a_q           <= a_d;
      b_q           <= b_d;
      rsp_c_q       <= rsp_c_d;
      rsp_err_q     <= rsp_err_d;
      gnt_q         <= gnt_d;
      rsp_valid_q   <= rsp_valid_d;
      tmo_q         <= tmo_d;
      start_rst_n_q <= start_rst_n_d;
    end
  end

  // Both terms are glitch-free: global reset and a registered start pulse.
  assign mul_rst_n = rst_n & start_rst_n_q;

  modmul_sched_barrett u_mul (
    .clk    (clk),
    .rst_n  (mul_rst_n),
    .a_i    (a_q),
    .b_i    (b_q),
    .done_o (mul_done),
    .c_o    (mul_c)
  );

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
